ifu_fetch: RTL and testbench

- Instruction-fetch front end. Consumes the PC stream from the PC generator and issues pipelined reads to instruction memory.
- Matches returned instruction words to their PCs and hands {pc, inst} pairs to decode over a valid/ready handshake.
- On a redirect (jump) it squashes buffered and in-flight fetches, so the PC generator only advances when a fetch is actually accepted.

---
 rtl/ifu_pkg.sv | 15 +
 rtl/ifu_fifo.sv | 72 +++++++
 rtl/ifu_fetch.sv | 109 ++++++++++
 tb/tb_ifu_fetch.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared constants and payload types for the instruction-fetch front end.
package ifu_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned IW   = 32;

  localparam logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [IW-1:0]   INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [IW-1:0]   inst;
  } ifu_resp_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with single-cycle clear; the head entry is always visible on data_o.
module ifu_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  input  logic                         clear_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is allowed only when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: credit-limited imem reads, in-order PC tagging,
// squash of in-flight reads on redirect, and a valid/ready handoff to decode.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  input  logic            pc_valid_i,
  output logic            pc_ready_o,
  input  logic            flush_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [IW-1:0]   imem_rdata_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [IW-1:0]   inst_o,
  output logic [XLEN-1:0] inst_pc_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned UW = CW + 1;
  localparam int unsigned RW = $bits(ifu_resp_t);

  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   resp_count;
  logic [UW-1:0]   used;
  logic            rsp_ok, rsp_keep, dec_pop;
  logic            resp_empty;
  logic [XLEN-1:0] tag_pc;
  ifu_resp_t       resp_in, resp_head;

  logic            unused_resp_full;
  logic            unused_tag_full, unused_tag_empty;
  logic [CW-1:0]   unused_tag_count;

  // Credit covers both reads still at the memory and words waiting for decode.
  assign used        = UW'(outstanding_q) + UW'(resp_count);
  assign imem_req_o  = ~rst & pc_valid_i & ~flush_i & (used < UW'(DEPTH));
  assign imem_addr_o = pc_i;
  assign pc_ready_o  = imem_req_o & imem_gnt_i;

  assign rsp_ok   = imem_rvalid_i & (outstanding_q != '0);
  assign rsp_keep = rsp_ok & (discard_q == '0) & ~flush_i;

  assign inst_valid_o = ~resp_empty & ~flush_i;
  assign dec_pop      = inst_valid_o & inst_ready_i;
  assign inst_o       = resp_head.inst;
  assign inst_pc_o    = resp_head.pc;

  assign resp_in.pc   = tag_pc;
  assign resp_in.inst = imem_rdata_i;

  // Words returning after a redirect belong to squashed fetches and are counted off.
  always_comb begin
    outstanding_d = outstanding_q + CW'(pc_ready_o) - CW'(rsp_ok);
    discard_d     = discard_q;
    if (flush_i) begin
      discard_d = outstanding_q - CW'(rsp_ok);
    end else if (rsp_ok && (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  ifu_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pc_ready_o),
    .data_i  (pc_i),
    .pop_i   (rsp_ok),
    .clear_i (1'b0),
    .data_o  (tag_pc),
    .full_o  (unused_tag_full),
    .empty_o (unused_tag_empty),
    .count_o (unused_tag_count)
  );

  ifu_fifo #(.WIDTH(RW), .DEPTH(DEPTH)) u_resp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rsp_keep),
    .data_i  (resp_in),
    .pop_i   (dec_pop),
    .clear_i (flush_i),
    .data_o  (resp_head),
    .full_o  (unused_resp_full),
    .empty_o (resp_empty),
    .count_o (resp_count)
  );

  // A read response with nothing outstanding is a memory-side protocol error.
  assert property (@(posedge clk) disable iff (rst) imem_rvalid_i |-> (outstanding_q != '0));

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed vector table plus scoreboarded random-latency stream and async-reset sequence for ifu_fetch.
`timescale 1ns/1ps
module tb_ifu_fetch;

  localparam int unsigned DEPTH = 2;
  localparam int          NF    = 1000;
  localparam logic [63:0] B     = 64'h0000_0000_8000_0000;
  localparam logic [63:0] NA    = 64'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc_i;
  logic        pc_valid_i;
  logic        pc_ready_o;
  logic        flush_i;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;

  ifu_fetch #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .pc_valid_i    (pc_valid_i),
    .pc_ready_o    (pc_ready_o),
    .flush_i       (flush_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_ready_i  (inst_ready_i),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [63:0] pc;
    logic        gnt;
    logic        rv;
    logic [63:0] rpc;
    logic        rdy;
    logic        fl;
    logic        req;
    logic        prdy;
    logic        ival;
    logic [63:0] ipc;
  } vec_t;

  typedef struct {
    logic [63:0] addr;
    int unsigned due;
  } mreq_t;

  vec_t        vt[$];
  mreq_t       mem_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] next_pc;
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_err = 0;
  int          n_iss, n_dec, n0, max_used;

  function automatic logic [31:0] wd(input logic [63:0] pc);
    return pc[31:0] ^ 32'h00A0_0013;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tv(input int pv, input logic [63:0] pc, input int g, input int rv,
                    input logic [63:0] rpc, input int rdy, input int fl,
                    input int req, input int prdy, input int ival, input logic [63:0] ipc);
    vec_t v;
    v.pv = (pv != 0); v.pc = pc; v.gnt = (g != 0); v.rv = (rv != 0); v.rpc = rpc;
    v.rdy = (rdy != 0); v.fl = (fl != 0); v.req = (req != 0); v.prdy = (prdy != 0);
    v.ival = (ival != 0); v.ipc = ipc;
    vt.push_back(v);
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    @(negedge clk);
    cyc++;
    pc_valid_i    = v.pv;
    pc_i          = v.pc;
    imem_gnt_i    = v.gnt;
    imem_rvalid_i = v.rv;
    imem_rdata_i  = v.rv ? wd(v.rpc) : 32'h0;
    inst_ready_i  = v.rdy;
    flush_i       = v.fl;
    #3;
    chk($sformatf("v%0d_req", idx), 64'(imem_req_o), 64'(v.req));
    chk($sformatf("v%0d_pc_ready", idx), 64'(pc_ready_o), 64'(v.prdy));
    chk($sformatf("v%0d_inst_valid", idx), 64'(inst_valid_o), 64'(v.ival));
    if (v.req) chk($sformatf("v%0d_addr", idx), imem_addr_o, v.pc);
    if (v.ival) begin
      chk($sformatf("v%0d_inst", idx), 64'(inst_o), 64'(wd(v.ipc)));
      chk($sformatf("v%0d_inst_pc", idx), inst_pc_o, v.ipc);
    end
  endtask

  // Memory model and decode scoreboard, evaluated just before the rising edge.
  task automatic observe();
    logic [63:0] e;
    if (imem_rvalid_i) void'(mem_q.pop_front());
    if (imem_req_o && imem_gnt_i)
      mem_q.push_back('{addr: imem_addr_o, due: cyc + $urandom_range(4, 1)});
    if (pc_ready_o) begin
      exp_q.push_back(pc_i);
      next_pc = next_pc + 64'd4;
      n_iss++;
    end
    if (inst_valid_o && inst_ready_i) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL decode_extra: got pc %h, required no transfer", inst_pc_o);
      end else begin
        e = exp_q.pop_front();
        chk("dec_pc", inst_pc_o, e);
        chk("dec_inst", 64'(inst_o), 64'(wd(e)));
      end
      n_dec++;
    end
    if (exp_q.size() > max_used) max_used = exp_q.size();
  endtask

  task automatic rcycle(input bit issue_en, input bit rnd);
    @(negedge clk);
    cyc++;
    pc_valid_i   = issue_en;
    pc_i         = next_pc;
    imem_gnt_i   = rnd ? ($urandom_range(3) != 0) : 1'b1;
    inst_ready_i = rnd ? ($urandom_range(3) != 0) : 1'b1;
    flush_i      = 1'b0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = wd(mem_q[0].addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0;
    end
    #3;
    observe();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; pc_i = B; pc_valid_i = 1'b1; flush_i = 1'b0; imem_gnt_i = 1'b1;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF; inst_ready_i = 1'b1;
    #3;
    chk("rst_req", 64'(imem_req_o), 64'd0);
    chk("rst_pc_ready", 64'(pc_ready_o), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid_o), 64'd0);
    chk("rst_inst", 64'(inst_o), 64'd0);
    chk("rst_inst_pc", inst_pc_o, 64'd0);
    @(negedge clk);
    rst = 1'b0; pc_valid_i = 1'b0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;

    // Streaming, backpressure, gnt stall, flush with pending decode and in-flight reads.
    tv(1, B+64'h00, 1, 0, NA,        1, 0,  1, 1, 0, NA);
    tv(1, B+64'h04, 1, 1, B+64'h00,  1, 0,  1, 1, 0, NA);
    tv(1, B+64'h08, 1, 1, B+64'h04,  1, 0,  0, 0, 1, B+64'h00);
    tv(1, B+64'h08, 1, 0, NA,        1, 0,  1, 1, 1, B+64'h04);
    tv(1, B+64'h0C, 1, 1, B+64'h08,  1, 0,  1, 1, 0, NA);
    tv(1, B+64'h10, 1, 1, B+64'h0C,  0, 0,  0, 0, 1, B+64'h08);
    for (int i = 0; i < 4; i++) tv(1, B+64'h10, 1, 0, NA, 0, 0,  0, 0, 1, B+64'h08);
    tv(1, B+64'h10, 1, 0, NA,        1, 0,  0, 0, 1, B+64'h08);
    tv(1, B+64'h10, 1, 0, NA,        1, 0,  1, 1, 1, B+64'h0C);
    tv(0, B+64'h14, 0, 1, B+64'h10,  1, 0,  0, 0, 0, NA);
    tv(0, B+64'h14, 0, 0, NA,        1, 0,  0, 0, 1, B+64'h10);
    tv(1, B+64'h20, 0, 0, NA,        1, 0,  1, 0, 0, NA);
    tv(1, B+64'h20, 1, 0, NA,        1, 0,  1, 1, 0, NA);
    tv(0, B+64'h24, 1, 0, NA,        1, 0,  0, 0, 0, NA);
    tv(0, B+64'h24, 0, 1, B+64'h20,  1, 0,  0, 0, 0, NA);
    tv(0, B+64'h24, 0, 0, NA,        1, 0,  0, 0, 1, B+64'h20);
    tv(1, B+64'h40, 1, 0, NA,        0, 0,  1, 1, 0, NA);
    tv(1, B+64'h44, 1, 1, B+64'h40,  0, 0,  1, 1, 0, NA);
    tv(1, B+64'h100, 1, 1, B+64'h44, 1, 1,  0, 0, 0, NA);
    tv(1, B+64'h100, 1, 0, NA,       1, 0,  1, 1, 0, NA);
    tv(1, B+64'h104, 1, 1, B+64'h100, 1, 0, 1, 1, 0, NA);
    tv(0, B+64'h108, 0, 1, B+64'h104, 1, 0, 0, 0, 1, B+64'h100);
    tv(0, B+64'h108, 0, 0, NA,       1, 0,  0, 0, 1, B+64'h104);
    tv(1, B+64'h10, 1, 0, NA,        1, 0,  1, 1, 0, NA);
    tv(1, B+64'h14, 1, 0, NA,        1, 0,  1, 1, 0, NA);
    tv(1, B+64'h100, 1, 0, NA,       1, 1,  0, 0, 0, NA);
    tv(1, B+64'h100, 1, 1, B+64'h10, 1, 0,  0, 0, 0, NA);
    tv(1, B+64'h100, 1, 1, B+64'h14, 1, 0,  1, 1, 0, NA);
    tv(1, B+64'h104, 1, 1, B+64'h100, 1, 0, 1, 1, 0, NA);
    tv(0, B+64'h108, 0, 1, B+64'h104, 1, 0, 0, 0, 1, B+64'h100);
    tv(0, B+64'h108, 0, 0, NA,       1, 0,  0, 0, 1, B+64'h104);
    tv(1, B+64'h10, 1, 0, NA,        1, 0,  1, 1, 0, NA);
    tv(1, B+64'h14, 1, 0, NA,        1, 0,  1, 1, 0, NA);
    tv(1, B+64'h200, 1, 1, B+64'h10, 1, 1,  0, 0, 0, NA);
    tv(1, B+64'h200, 1, 0, NA,       1, 0,  1, 1, 0, NA);
    tv(1, B+64'h204, 1, 1, B+64'h14, 1, 0,  0, 0, 0, NA);
    tv(0, B+64'h208, 0, 1, B+64'h200, 1, 0, 0, 0, 0, NA);
    tv(0, B+64'h208, 0, 0, NA,       1, 0,  0, 0, 1, B+64'h200);
    foreach (vt[i]) apply_vec(vt[i], i);

    // Random gnt stalls, decode stalls and 1-4 cycle memory latency.
    n_iss = 0; n_dec = 0; max_used = 0; next_pc = B + 64'h1000;
    for (int c = 0; c < 20000 && n_dec < NF; c++) rcycle(n_iss < NF, 1'b1);
    chk("random_decoded", 64'(n_dec), 64'(NF));
    chk("random_leftover", 64'(exp_q.size()), 64'd0);
    n_chk++;
    if (max_used > int'(DEPTH)) begin
      n_err++;
      $display("FAIL random_inflight: got %0d, required at most %0d", max_used, DEPTH);
    end

    // Async reset between edges while fetching, then restart.
    next_pc = B + 64'h2000;
    for (int c = 0; c < 6; c++) rcycle(1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", 64'(imem_req_o), 64'd0);
    chk("arst_pc_ready", 64'(pc_ready_o), 64'd0);
    chk("arst_inst_valid", 64'(inst_valid_o), 64'd0);
    chk("arst_inst", 64'(inst_o), 64'd0);
    chk("arst_inst_pc", inst_pc_o, 64'd0);
    mem_q.delete();
    exp_q.delete();
    @(negedge clk);
    cyc++;
    pc_valid_i = 1'b1; imem_gnt_i = 1'b1; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    cyc++;
    rst = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    pc_valid_i = 1'b1; pc_i = B; imem_gnt_i = 1'b1; inst_ready_i = 1'b1;
    next_pc = B;
    #3;
    chk("post_rst_req", 64'(imem_req_o), 64'd1);
    chk("post_rst_addr", imem_addr_o, B);
    chk("post_rst_inst_valid", 64'(inst_valid_o), 64'd0);
    n0 = n_dec;
    observe();
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) rcycle(1'b0, 1'b0);
    for (int c = 0; c < 3; c++) rcycle(1'b0, 1'b0);
    chk("post_rst_decoded", 64'(n_dec - n0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
